// File: rtl/gba_gpu_fb_arbiter.sv
// Framebuffer write arbiter: two pixel streams, each with its own FIFO,
// merged round-robin into one valid/ready framebuffer write port.
// Framebuffer addresses are computed at push time and stored in the FIFOs.

module gba_gpu_fb_arbiter_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 36
) (
    input  logic         fclk,
    input  logic         reset,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output logic         empty_o,
    output logic         full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign do_push = push_i & (~full_o | pop_i);
    assign do_pop  = pop_i & ~empty_o;
    assign rdata_o = mem_q[rd_q];

    // Storage array; contents need no reset because the count gates visibility.
    always_ff @(posedge fclk) begin
        if (do_push) mem_q[wr_q] <= wdata_i;
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge fclk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

module gba_gpu_fb_arbiter #(
    parameter int FIFO_DEPTH = 8,
    parameter int FB_AW      = 18
) (
    input  logic             fclk,
    input  logic             reset,
    input  logic             hdmode2x,
    input  logic [15:0]      pixel_in_addr,
    input  logic [8:0]       pixel_in_2x,
    input  logic [7:0]       pixel_in_y,
    input  logic [17:0]      pixel_in_data,
    input  logic             pixel_in_we,
    input  logic [8:0]       pixel2_in_2x,
    input  logic [7:0]       pixel2_in_y,
    input  logic [17:0]      pixel2_in_data,
    input  logic             pixel2_in_we,
    output logic [FB_AW-1:0] fb_addr,
    output logic [17:0]      fb_data,
    output logic             fb_we,
    input  logic             fb_ready,
    input  logic             clear_ovf,
    output logic             ovf_primary,
    output logic             ovf_secondary,
    output logic             busy
);
    localparam int EW = FB_AW + 18;

    typedef enum logic {RR_PRI, RR_SEC} rr_e;

    // 480*row without a multiplier; 18 bits are enough for row <= 319.
    function automatic logic [17:0] hd_addr(input logic [8:0] row, input logic [8:0] x);
        logic [17:0] r;
        r = {9'd0, row};
        return (r << 9) - (r << 5) + {9'd0, x};
    endfunction

    logic [17:0]   addr_p18, addr_s18;
    logic [EW-1:0] wdat_p, wdat_s, head_p, head_s;
    logic          empty_p, empty_s, full_p, full_s;
    logic          load, gnt_p, gnt_s;
    logic          drop_p, drop_s;
    logic          ovf_p_d, ovf_s_d;
    logic          fb_we_q, ovf_p_q, ovf_s_q;
    logic [FB_AW-1:0] fb_addr_q;
    logic [17:0]   fb_data_q;
    rr_e           rr_q;

    // Primary rows are even lines in hd mode, secondary rows are the odd ones.
    assign addr_p18 = hdmode2x ? hd_addr({pixel_in_y, 1'b0}, pixel_in_2x) : {2'b00, pixel_in_addr};
    assign addr_s18 = hd_addr({pixel2_in_y, 1'b1}, pixel2_in_2x);
    assign wdat_p   = {FB_AW'(addr_p18), pixel_in_data};
    assign wdat_s   = {FB_AW'(addr_s18), pixel2_in_data};

    // The output register can take a new word when empty or when its word is leaving.
    assign load  = ~fb_we_q | fb_ready;
    assign gnt_p = load & ~empty_p & (empty_s | (rr_q == RR_PRI));
    assign gnt_s = load & ~empty_s & (empty_p | (rr_q == RR_SEC));

    assign drop_p  = pixel_in_we  & full_p & ~gnt_p;
    assign drop_s  = pixel2_in_we & full_s & ~gnt_s;
    // Set wins over clear so a drop in the clearing cycle is never lost.
    assign ovf_p_d = (ovf_p_q & ~clear_ovf) | drop_p;
    assign ovf_s_d = (ovf_s_q & ~clear_ovf) | drop_s;

    gba_gpu_fb_arbiter_fifo #(.DEPTH(FIFO_DEPTH), .W(EW)) u_fifo_p (
        .fclk(fclk), .reset(reset), .push_i(pixel_in_we), .pop_i(gnt_p),
        .wdata_i(wdat_p), .rdata_o(head_p), .empty_o(empty_p), .full_o(full_p)
    );

    gba_gpu_fb_arbiter_fifo #(.DEPTH(FIFO_DEPTH), .W(EW)) u_fifo_s (
        .fclk(fclk), .reset(reset), .push_i(pixel2_in_we), .pop_i(gnt_s),
        .wdata_i(wdat_s), .rdata_o(head_s), .empty_o(empty_s), .full_o(full_s)
    );

    // Output register and round-robin pointer: the pointer always ends on the
    // source that was not just granted.
    always_ff @(posedge fclk) begin
        if (reset) begin
            fb_we_q   <= 1'b0;
            fb_addr_q <= '0;
            fb_data_q <= '0;
            rr_q      <= RR_PRI;
        end else if (load) begin
            if (gnt_p) begin
                {fb_addr_q, fb_data_q} <= head_p;
                fb_we_q <= 1'b1;
                rr_q    <= RR_SEC;
            end else if (gnt_s) begin
                {fb_addr_q, fb_data_q} <= head_s;
                fb_we_q <= 1'b1;
                rr_q    <= RR_PRI;
            end else begin
                fb_we_q <= 1'b0;
            end
        end
    end

    // Sticky overflow flags.
    always_ff @(posedge fclk) begin
        if (reset) begin
            ovf_p_q <= 1'b0;
            ovf_s_q <= 1'b0;
        end else begin
            ovf_p_q <= ovf_p_d;
            ovf_s_q <= ovf_s_d;
        end
    end

    assign fb_we         = fb_we_q;
    assign fb_addr       = fb_addr_q;
    assign fb_data       = fb_data_q;
    assign ovf_primary   = ovf_p_q;
    assign ovf_secondary = ovf_s_q;
    assign busy          = ~empty_p | ~empty_s | fb_we_q;
endmodule

// File: tb/tb_gba_gpu_fb_arbiter.sv
// Scoreboard bench for gba_gpu_fb_arbiter: stimulus queues expected writes,
// a negedge monitor pops and compares every accepted framebuffer write.

module tb_gba_gpu_fb_arbiter;
    localparam int DEPTH = 8;

    logic        fclk = 1'b0;
    logic        reset = 1'b1;
    logic        hdmode2x = 1'b0;
    logic [15:0] pixel_in_addr = '0;
    logic [8:0]  pixel_in_2x = '0;
    logic [7:0]  pixel_in_y = '0;
    logic [17:0] pixel_in_data = '0;
    logic        pixel_in_we = 1'b0;
    logic [8:0]  pixel2_in_2x = '0;
    logic [7:0]  pixel2_in_y = '0;
    logic [17:0] pixel2_in_data = '0;
    logic        pixel2_in_we = 1'b0;
    logic [17:0] fb_addr;
    logic [17:0] fb_data;
    logic        fb_we;
    logic        fb_ready = 1'b0;
    logic        clear_ovf = 1'b0;
    logic        ovf_primary, ovf_secondary, busy;

    gba_gpu_fb_arbiter #(.FIFO_DEPTH(DEPTH), .FB_AW(18)) dut (
        .fclk(fclk), .reset(reset), .hdmode2x(hdmode2x),
        .pixel_in_addr(pixel_in_addr), .pixel_in_2x(pixel_in_2x),
        .pixel_in_y(pixel_in_y), .pixel_in_data(pixel_in_data),
        .pixel_in_we(pixel_in_we), .pixel2_in_2x(pixel2_in_2x),
        .pixel2_in_y(pixel2_in_y), .pixel2_in_data(pixel2_in_data),
        .pixel2_in_we(pixel2_in_we), .fb_addr(fb_addr), .fb_data(fb_data),
        .fb_we(fb_we), .fb_ready(fb_ready), .clear_ovf(clear_ovf),
        .ovf_primary(ovf_primary), .ovf_secondary(ovf_secondary), .busy(busy)
    );

    always #5 fclk = ~fclk;

    typedef struct packed {
        logic [17:0] a;
        logic [17:0] d;
    } exp_t;

    exp_t expq[$];
    int   n_chk = 0;
    int   n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, expv);
    endtask

    // Monitor: compares each accepted write and checks stall stability.
    logic        hold_v = 1'b0;
    logic [35:0] held;
    always @(negedge fclk) begin
        exp_t e;
        if (reset) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) chk("stall hold", {fb_we, fb_addr, fb_data}, {1'b1, held});
            if (fb_we && fb_ready) begin
                if (expq.size() == 0) begin
                    chk("unexpected write", {fb_addr, fb_data}, 64'hDEAD_BEEF_0000);
                end else begin
                    e = expq.pop_front();
                    chk("write", {fb_addr, fb_data}, {e.a, e.d});
                end
            end
            hold_v = fb_we && !fb_ready;
            held   = {fb_addr, fb_data};
        end
    end

    task automatic tick();
        @(posedge fclk);
        #1;
        pixel_in_we  = 1'b0;
        pixel2_in_we = 1'b0;
        clear_ovf    = 1'b0;
    endtask

    task automatic setp(input logic [15:0] a, input logic [8:0] x, input logic [7:0] y, input logic [17:0] d);
        pixel_in_addr = a; pixel_in_2x = x; pixel_in_y = y; pixel_in_data = d; pixel_in_we = 1'b1;
    endtask

    task automatic sets(input logic [8:0] x, input logic [7:0] y, input logic [17:0] d);
        pixel2_in_2x = x; pixel2_in_y = y; pixel2_in_data = d; pixel2_in_we = 1'b1;
    endtask

    task automatic expw(input logic [17:0] a, input logic [17:0] d);
        expq.push_back('{a: a, d: d});
    endtask

    // Bounded drain: the queue must be empty and the block idle afterwards.
    task automatic drain(input string nm);
        fb_ready = 1'b1;
        for (int i = 0; i < 40 && (expq.size() != 0 || busy); i++) tick();
        tick();
        chk({nm, " drained"}, expq.size(), 0);
        chk({nm, " busy"}, busy, 0);
        expq.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    logic pat [10] = '{0, 1, 0, 0, 1, 1, 1, 1, 1, 1};

    initial begin
        // Reset state
        do_reset();
        chk("rst fb_we", fb_we, 0);
        chk("rst busy", busy, 0);
        chk("rst ovf", {ovf_primary, ovf_secondary}, 0);
        chk("rst addr/data", {fb_addr, fb_data}, 0);

        // Low-res pass-through and first-write latency
        hdmode2x = 1'b0;
        fb_ready = 1'b1;
        setp(16'd0, 9'd0, 8'd0, 18'h3FFFF); expw(18'd0, 18'h3FFFF);
        tick();
        chk("latency edge N", fb_we, 0);
        setp(16'd1, 9'd0, 8'd0, 18'h00001); expw(18'd1, 18'h00001);
        tick();
        chk("latency edge N+1", {fb_we, fb_addr}, {1'b1, 18'd0});
        setp(16'd38399, 9'd0, 8'd0, 18'h15555); expw(18'd38399, 18'h15555);
        tick();
        drain("lowres");

        // Hd address math: (2y)*480+x for primary, (2y+1)*480+x for secondary
        hdmode2x = 1'b1;
        setp(16'd0, 9'd479, 8'd158, 18'h00AAA); expw(18'd152159, 18'h00AAA);
        tick(); tick(); tick();
        setp(16'd0, 9'd479, 8'd159, 18'h00BBB); expw(18'd153119, 18'h00BBB);
        tick(); tick(); tick();
        sets(9'd5, 8'd0, 18'h00CCC); expw(18'd485, 18'h00CCC);
        tick();
        drain("hd");
        hdmode2x = 1'b0;

        // Round-robin with both FIFOs backlogged
        do_reset();
        fb_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            setp(16'(10 + i), 9'd0, 8'd0, 18'(18'h100 + i));
            sets(9'(i), 8'(i), 18'(18'h200 + i));
            tick();
        end
        expw(18'd10, 18'h100); expw(18'd480,  18'h200);
        expw(18'd11, 18'h101); expw(18'd1441, 18'h201);
        expw(18'd12, 18'h102); expw(18'd2402, 18'h202);
        tick(); tick();
        chk("rr stalled head", {busy, fb_we, fb_addr}, {2'b11, 18'd10});
        drain("rr");

        // Backpressure pattern during a primary stream
        for (int i = 0; i < 10; i++) begin
            fb_ready = pat[i];
            if (i < 5) begin
                setp(16'(200 + i), 9'd0, 8'd0, 18'(18'h300 + i));
                expw(18'(200 + i), 18'(18'h300 + i));
            end
            tick();
        end
        drain("bp");

        // Overflow: output register holds one word, the FIFO the next DEPTH,
        // so DEPTH+1 are written and the last push is dropped.
        do_reset();
        fb_ready = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            setp(16'(300 + i), 9'd0, 8'd0, 18'(18'h400 + i));
            if (i < DEPTH + 1) expw(18'(300 + i), 18'(18'h400 + i));
            tick();
        end
        chk("ovf primary set", {ovf_primary, ovf_secondary}, 2'b10);
        drain("ovf");
        chk("ovf sticky", ovf_primary, 1);
        clear_ovf = 1'b1;
        tick();
        chk("ovf cleared", ovf_primary, 0);
        fb_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            setp(16'(400 + i), 9'd0, 8'd0, 18'(18'h500 + i));
            expw(18'(400 + i), 18'(18'h500 + i));
            tick();
        end
        chk("no ovf when full", ovf_primary, 0);
        setp(16'd999, 9'd0, 8'd0, 18'h3ABCD);
        clear_ovf = 1'b1;
        tick();
        chk("set wins over clear", {ovf_primary, ovf_secondary}, 2'b10);
        drain("ovf2");

        // Reset mid-stream
        do_reset();
        fb_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            setp(16'(500 + i), 9'd0, 8'd0, 18'(18'h600 + i));
            sets(9'(i), 8'd1, 18'(18'h700 + i));
            tick();
        end
        chk("pre-reset pending", {busy, fb_we}, 2'b11);
        reset = 1'b1;
        tick();
        chk("mid reset state", {fb_we, busy, ovf_primary, ovf_secondary}, 0);
        chk("mid reset addr", fb_addr, 0);
        reset = 1'b0;
        setp(16'd100, 9'd0, 8'd0, 18'h12345); expw(18'd100, 18'h12345);
        sets(9'd7, 8'd2, 18'h2BCDE);           expw(18'd2407, 18'h2BCDE);
        fb_ready = 1'b1;
        tick();
        drain("post reset");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end
endmodule
